// File: rtl/airlock_evacuate.sv
// Airlock evacuation sequencer.
// Moore FSM: IDLE -> PUMP (pump runs EVAC_CYCLES cycles) -> HOLD (chamber
// at vacuum, downstream fill-and-pressurize requested) -> IDLE.
// Any door opening during PUMP or HOLD latches FAULT. FAULT is left only by
// an explicit clear_fault while both doors are closed.
// All outputs are decoded from the state register alone. An asynchronous
// reset therefore clears them immediately, without waiting for a clock edge.
module airlock_evacuate #(
  parameter int EVAC_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic begin_Evac,
  input  logic abort,
  input  logic clear_fault,
  input  logic InnerClosed,
  input  logic OuterClosed,
  input  logic Pressurized,
  output logic Evacuate,
  output logic Evacuated,
  output logic begin_FandP,
  output logic Busy,
  output logic Fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUMP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Terminal value of the pump counter. The counter starts at 0 on PUMP
  // entry, so reaching this value means EVAC_CYCLES pump cycles have elapsed.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(EVAC_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             seen_low;
  logic             seen_low_next;

  logic doors_closed;
  logic start_ok;
  logic terminal;

  assign doors_closed = InnerClosed & OuterClosed;
  assign start_ok     = begin_Evac & doors_closed & Pressurized;
  assign terminal     = (count == LAST_COUNT);

  // State, pump counter and pressure-drop flag registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      seen_low <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      seen_low <= seen_low_next;
    end
  end

  // Next-state logic, counter and flag updates, and Moore output decode.
  always_comb begin
    state_next    = state;
    count_next    = '0;      // counter is held at 0 everywhere but PUMP
    seen_low_next = 1'b0;    // flag only carries meaning inside HOLD
    Evacuate      = 1'b0;
    Evacuated     = 1'b0;
    begin_FandP   = 1'b0;
    Busy          = 1'b0;
    Fault         = 1'b0;

    case (state)
      IDLE: begin
        // A held request restarts the cycle as soon as the
        // start conditions hold. Nothing is queued from other states.
        if (start_ok) begin
          state_next = PUMP;
        end
      end

      PUMP: begin
        Evacuate = 1'b1;
        Busy     = 1'b1;
        // A door fault outranks abort. Abort outranks completion.
        if (!doors_closed) begin
          state_next = FAULT;
        end else if (abort) begin
          state_next = IDLE;
        end else if (terminal) begin
          state_next = HOLD;   // seen_low_next stays 0: cleared on HOLD entry
        end else begin
          count_next = count + 1'b1;
        end
      end

      HOLD: begin
        Evacuated   = 1'b1;
        begin_FandP = 1'b1;
        Busy        = 1'b1;
        // Pressure must first be seen low in HOLD. A Pressurized level
        // left over from before the pump ran must not end the cycle.
        seen_low_next = seen_low | ~Pressurized;
        if (!doors_closed) begin
          state_next = FAULT;
        end else if (abort) begin
          state_next = IDLE;
        end else if (Pressurized && seen_low) begin
          state_next = IDLE;
        end
      end

      FAULT: begin
        Fault = 1'b1;
        if (clear_fault && doors_closed) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/airlock_evacuate.md
AIRLOCK_EVACUATE -- requirements
Module: airlock_evacuate

Interface
REQ-001 Parameter EVAC_CYCLES, default 16, is the number of clock cycles the pump runs; the legal range is 1..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 8, is the width of the pump-duration counter.
REQ-003 Port Clock, input, 1 bit, is the single clock; all state updates occur on its rising edge.
REQ-004 Port Reset, input, 1 bit, is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port begin_Evac, input, 1 bit, is the level request to start evacuation.
REQ-006 Port abort, input, 1 bit, cancels the cycle and returns the block to idle.
REQ-007 Port clear_fault, input, 1 bit, acknowledges and clears a fault.
REQ-008 Port InnerClosed, input, 1 bit, means the inner door is closed.
REQ-009 Port OuterClosed, input, 1 bit, means the outer door is closed.
REQ-010 Port Pressurized, input, 1 bit, means the chamber is at pressure (pressure sensor).
REQ-011 Port Evacuate, output, 1 bit, is the pump-enable.
REQ-012 Port Evacuated, output, 1 bit, means the chamber is at vacuum; it feeds the downstream fill-and-pressurize stage.
REQ-013 Port begin_FandP, output, 1 bit, is the level request to the downstream fill-and-pressurize stage.
REQ-014 Port Busy, output, 1 bit, is high while in PUMP or HOLD.
REQ-015 Port Fault, output, 1 bit, is high when a door opened during a cycle.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, PUMP, HOLD and FAULT, and all outputs SHALL be registered or decoded from state only.
REQ-017 Outputs by state:
- IDLE: all outputs 0.
- PUMP: Evacuate=1 and Busy=1.
- HOLD: Evacuated=1, begin_FandP=1 and Busy=1.
- FAULT: Fault=1 only.
REQ-018 IDLE->PUMP SHALL occur when begin_Evac && InnerClosed && OuterClosed && Pressurized; otherwise the block stays in IDLE.
REQ-019 On entry to PUMP the counter SHALL load 0 and increment once per PUMP cycle.
REQ-020 PUMP->HOLD SHALL occur when count==EVAC_CYCLES-1, so Evacuate is high for exactly EVAC_CYCLES cycles.
REQ-021 Latency: if the request is sampled at edge k, Evacuate rises after edge k and Evacuated rises after edge k+EVAC_CYCLES.
REQ-022 PUMP priority, per cycle:
- (!InnerClosed || !OuterClosed) -> FAULT.
- else abort -> IDLE.
- else terminal count -> HOLD.
- else stay in PUMP.
REQ-023 HOLD priority, per cycle:
- door open -> FAULT.
- else abort -> IDLE.
- else Pressurized -> IDLE (downstream refill complete).
- else stay in HOLD.
REQ-024 A Pressurized level that is still high on the cycle HOLD is entered SHALL NOT cause an exit; the HOLD->IDLE exit requires Pressurized to have been low on at least one prior HOLD cycle, tracked by a 1-bit seen_low flag cleared on HOLD entry.
REQ-025 FAULT->IDLE SHALL occur only when clear_fault && InnerClosed && OuterClosed; otherwise the block stays in FAULT.
REQ-026 begin_Evac asserted in any state other than IDLE SHALL be ignored, with no queueing.
REQ-027 After a return to IDLE, a begin_Evac level that is still held SHALL restart the cycle on the next edge if all start conditions hold.
REQ-028 The counter SHALL never wrap; it is held at 0 outside PUMP.
REQ-029 Evacuate and Evacuated SHALL never be high in the same cycle.

Reset
REQ-030 While Reset=0 the state SHALL be IDLE, the counter 0, seen_low 0 and every output 0, asynchronously and without waiting for a clock edge.
REQ-031 Reset deassertion SHALL take effect on the next rising Clock edge, with the block in IDLE.
REQ-032 Reset asserted mid-PUMP or mid-HOLD SHALL drop Evacuate, Evacuated and begin_FandP immediately.

Verification
REQ-033 Nominal cycle (EVAC_CYCLES=4):
- Stimulus: doors closed, Pressurized=1, begin_Evac pulsed at edge 0.
- Response: Evacuate=1 for edges 1-4; Evacuated=1 and begin_FandP=1 from edge 4.
- Then Pressurized held 0 for 3 cycles, then 1: IDLE and all outputs 0 on the following edge.
REQ-034 Door open mid-pump:
- Stimulus: OuterClosed=0 at PUMP count 2.
- Response: Fault=1 and Evacuate=0 on the next edge.
- Then clear_fault=1 with doors still open: block stays in FAULT.
- Then doors closed with clear_fault=1: IDLE.
REQ-035 Simultaneous events in PUMP:
- Stimulus: abort=1 and InnerClosed=0 in the same PUMP cycle.
- Response: FAULT (not IDLE).
REQ-036 Start-condition gating:
- Stimulus: begin_Evac=1 with Pressurized=0 or either door open.
- Response: block stays in IDLE with all outputs 0 for 10 cycles.
REQ-037 Asynchronous reset:
- Stimulus: Reset=0 mid-cycle between clock edges during PUMP.
- Response: Evacuate=0 before the next edge; after release, a new begin_Evac yields exactly EVAC_CYCLES pump cycles.
REQ-038 EVAC_CYCLES=1 boundary:
- Response: Evacuate high for one cycle, then HOLD.
- Checker: Evacuate and Evacuated are never both high.
